// File: rtl/stepper_move_sequencer.sv
// Move sequencer: buffers signed X/Y step pairs in a small FIFO and hands
// them one at a time to an XY stepper controller over trigger/done, paced
// by the shared clk_en tick. All-zero pairs are retired without a trigger.
module stepper_move_sequencer #(
  parameter int COUNT_BITS_X = 8,
  parameter int COUNT_BITS_Y = 8,
  parameter int DEPTH        = 4,
  parameter int MOVES_BITS   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_en,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [COUNT_BITS_X-1:0] in_steps_x,
  input  logic signed [COUNT_BITS_Y-1:0] in_steps_y,
  input  logic                           run,
  input  logic                           flush,
  input  logic                           ctrl_done,
  output logic                           trigger,
  output logic signed [COUNT_BITS_X-1:0] num_steps_x,
  output logic signed [COUNT_BITS_Y-1:0] num_steps_y,
  output logic                           busy,
  output logic [$clog2(DEPTH):0]         level,
  output logic [MOVES_BITS-1:0]          moves_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRIGGER   = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic signed [COUNT_BITS_X-1:0] mem_x [DEPTH];
  logic signed [COUNT_BITS_Y-1:0] mem_y [DEPTH];
  logic [PTR_W-1:0]               wr_ptr, rd_ptr;

  logic                           full;
  logic                           wr_en;
  logic                           can_pop;
  logic                           pop;
  logic                           latch;
  logic [1:0]                     move_inc;
  logic signed [COUNT_BITS_X-1:0] head_x;
  logic signed [COUNT_BITS_Y-1:0] head_y;
  logic                           head_zero;

  // in_ready looks at the pre-pop level, so a full FIFO refuses a write
  // even on the tick that pops; flush also drops the same-cycle write
  assign full      = (level == LVL_W'(DEPTH));
  assign in_ready  = !full;
  assign wr_en     = in_valid && !full && !flush;
  assign head_x    = mem_x[rd_ptr];
  assign head_y    = mem_y[rd_ptr];
  assign head_zero = (head_x == '0) && (head_y == '0);
  // a flush on the same edge wins over a pop so nothing stale gets dispatched
  assign can_pop   = run && (level != '0) && !flush;
  assign trigger   = (state == TRIGGER);
  assign busy      = (state != IDLE);

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_x[wr_ptr] <= in_steps_x;
      mem_y[wr_ptr] <= in_steps_y;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // dispatch decisions: pop/latch/count only on clk_en ticks
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    latch      = 1'b0;
    move_inc   = 2'd0;
    if (clk_en) begin
      case (state)
        IDLE: begin
          if (can_pop && ctrl_done) begin
            pop = 1'b1;
            if (head_zero) begin
              move_inc = 2'd1;
            end else begin
              latch      = 1'b1;
              state_next = TRIGGER;
            end
          end
        end
        TRIGGER: begin
          state_next = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (ctrl_done) begin
            move_inc   = 2'd1;
            state_next = IDLE;
            // chain straight into the next move to keep 2-tick spacing
            if (can_pop) begin
              pop = 1'b1;
              if (head_zero) begin
                move_inc = 2'd2;
              end else begin
                latch      = 1'b1;
                state_next = TRIGGER;
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // state, latched move and completed-move counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      num_steps_x <= '0;
      num_steps_y <= '0;
      moves_done  <= '0;
    end else begin
      state      <= state_next;
      moves_done <= moves_done + MOVES_BITS'(move_inc);
      if (latch) begin
        num_steps_x <= head_x;
        num_steps_y <= head_y;
      end
    end
  end

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Bench for stepper_move_sequencer: directed scenarios plus a randomized
// phase, all compared each clock against a queue-based reference model.
module tb_stepper_move_sequencer;

  localparam int DEPTH = 4;
  localparam int MB    = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clk_en = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [7:0] in_steps_x = '0;
  logic signed [7:0] in_steps_y = '0;
  logic              run = 1'b0;
  logic              flush = 1'b0;
  logic              ctrl_done = 1'b1;
  logic              trigger;
  logic signed [7:0] num_steps_x;
  logic signed [7:0] num_steps_y;
  logic              busy;
  logic [2:0]        level;
  logic [MB-1:0]     moves_done;

  stepper_move_sequencer #(
    .COUNT_BITS_X(8), .COUNT_BITS_Y(8), .DEPTH(DEPTH), .MOVES_BITS(MB)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_steps_x(in_steps_x), .in_steps_y(in_steps_y),
    .run(run), .flush(flush), .ctrl_done(ctrl_done), .trigger(trigger),
    .num_steps_x(num_steps_x), .num_steps_y(num_steps_y), .busy(busy),
    .level(level), .moves_done(moves_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] x; logic [7:0] y; } pair_t;

  // reference model: pending moves, what the sequencer is doing, counters
  localparam int P_IDLE = 0, P_TRIG = 1, P_WAIT = 2;
  pair_t      q[$];
  int         m_phase = P_IDLE;
  logic [7:0] m_x = '0, m_y = '0;
  logic [MB-1:0] m_moves = '0;

  int total = 0, passed = 0;
  int ce_mode = 0;
  int dur = 3;
  int rem = 0;
  int trig_cnt = 0;
  logic [7:0]    trig_x[$], trig_y[$];
  logic [MB-1:0] trig_moves[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_phase = P_IDLE;
    m_x = '0; m_y = '0; m_moves = '0;
  endtask

  // one clock edge of the sequencer described by its rules
  task automatic model_edge(input logic v, input pair_t d, input logic r,
                            input logic fl, input logic dn, input logic ce);
    int    lvl = q.size();
    bit    accept = v && (lvl < DEPTH) && !fl;
    bit    take = 0;
    pair_t h;
    if (ce) begin
      if (m_phase == P_IDLE) begin
        take = r && lvl > 0 && dn && !fl;
      end else if (m_phase == P_TRIG) begin
        m_phase = P_WAIT;
      end else if (dn) begin
        m_moves = m_moves + 1'b1;
        m_phase = P_IDLE;
        take = r && lvl > 0 && !fl;
      end
    end
    if (take) begin
      h = q.pop_front();
      if (h.x == 0 && h.y == 0) m_moves = m_moves + 1'b1;
      else begin m_x = h.x; m_y = h.y; m_phase = P_TRIG; end
    end
    if (fl) q.delete();
    if (accept) q.push_back(d);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_trigger"}, trigger, m_phase == P_TRIG);
    chk({tag, "_busy"}, busy, m_phase != P_IDLE);
    chk({tag, "_level"}, level, q.size());
    chk({tag, "_in_ready"}, in_ready, q.size() < DEPTH);
    chk({tag, "_nsx"}, $unsigned(num_steps_x), m_x);
    chk({tag, "_nsy"}, $unsigned(num_steps_y), m_y);
    chk({tag, "_moves"}, moves_done, m_moves);
  endtask

  // downstream controller: drops done when it samples trigger, raises it dur ticks later
  task automatic respond(input logic t_pre, input logic ce);
    if (ce) begin
      if (t_pre) begin
        ctrl_done = 1'b0;
        rem = dur;
      end else if (!ctrl_done) begin
        rem--;
        if (rem <= 0) ctrl_done = 1'b1;
      end
    end
  endtask

  task automatic step();
    logic  t_pre = trigger;
    logic  ce = clk_en;
    pair_t d = {in_steps_x, in_steps_y};
    logic  v = in_valid, r = run, fl = flush, dn = ctrl_done;
    @(posedge clk);
    model_edge(v, d, r, fl, dn, ce);
    #1;
    respond(t_pre, ce);
    if (trigger && !t_pre) begin
      trig_cnt++;
      trig_x.push_back(num_steps_x);
      trig_y.push_back(num_steps_y);
      trig_moves.push_back(moves_done);
    end
    check_all("cyc");
  endtask

  task automatic cyc();
    case (ce_mode)
      0: clk_en = 1'b1;
      1: clk_en = ~clk_en;
      default: clk_en = 1'($urandom_range(0, 1));
    endcase
    step();
  endtask

  task automatic push(input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1; in_steps_x = x; in_steps_y = y;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || !ctrl_done || (run && level != 0)) && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_idle_timeout"}, n < budget, 1);
  endtask

  task automatic wait_trigger(input string tag, input int budget);
    int n = 0;
    while (!trigger && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_trig_timeout"}, n < budget, 1);
  endtask

  initial begin
    int b;
    logic [MB-1:0] mb;
    #2;
    model_reset();
    check_all("reset");
    #10 reset = 1'b0;

    // 1: four moves back to back, 3-tick downstream moves
    run = 1'b1;
    b = trig_cnt;
    push(8'd2, 8'd3); push(8'd0, -8'sd5); push(-8'sd7, 8'd4); push(-8'sd2, 8'd0);
    wait_idle("t1", 200);
    chk("t1_trig_count", trig_cnt - b, 4);
    chk("t1_y_second", trig_y[b+1], 8'hFB);
    chk("t1_x_fourth", trig_x[b+3], 8'hFE);
    chk("t1_moves", moves_done, 4);

    // 2: fill with run low, 5th offer refused, ready returns after a pop
    ce_mode = 1;
    run = 1'b0;
    push(8'd1, 8'd2); push(8'd3, 8'd4); push(8'd5, 8'd6); push(8'd7, 8'd8);
    chk("t2_ready_full", in_ready, 0);
    push(8'd9, 8'd9);
    chk("t2_level_full", level, 4);
    run = 1'b1;
    wait_trigger("t2", 20);
    chk("t2_ready_back", in_ready, 1);
    wait_idle("t2", 300);

    // 3: zero move skipped before the real one
    run = 1'b0;
    b = trig_cnt;
    mb = m_moves;
    push(8'd0, 8'd0); push(8'd1, 8'd1);
    run = 1'b1;
    wait_idle("t3", 100);
    chk("t3_trig_count", trig_cnt - b, 1);
    chk("t3_moves_at_trig", trig_moves[b], mb + 1'b1);
    chk("t3_x_at_trig", trig_x[b], 8'd1);

    // 4: flush while waiting with two queued
    ce_mode = 0;
    run = 1'b0;
    push(8'd10, 8'd11); push(8'd12, 8'd13); push(8'd14, 8'd15);
    run = 1'b1;
    b = trig_cnt;
    mb = m_moves;
    wait_trigger("t4", 10);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t4_level_flushed", level, 0);
    wait_idle("t4", 50);
    chk("t4_trig_count", trig_cnt - b, 1);
    chk("t4_moves", moves_done, mb + 1'b1);

    // 5: run dropped mid-move with one queued, then resumed
    run = 1'b0;
    push(8'd20, 8'd21); push(8'd22, 8'd23);
    run = 1'b1;
    wait_trigger("t5", 10);
    cyc();
    run = 1'b0;
    b = trig_cnt;
    wait_idle("t5", 50);
    for (int i = 0; i < 3; i++) cyc();
    chk("t5_no_trig", trig_cnt - b, 0);
    chk("t5_level_held", level, 1);
    run = 1'b1;
    cyc(); cyc();
    chk("t5_resume_trig", trig_cnt - b, 1);
    wait_idle("t5b", 50);

    // randomized traffic with random pacing, move lengths and zero moves
    ce_mode = 2;
    for (int i = 0; i < 600; i++) begin
      dur = $urandom_range(1, 4);
      run = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) == 0) begin
        in_steps_x = '0; in_steps_y = '0;
      end else begin
        in_steps_x = 8'($urandom); in_steps_y = 8'($urandom);
      end
      step_rand();
    end
    in_valid = 1'b0; flush = 1'b0; run = 1'b1;
    wait_idle("rand", 400);

    // 6: asynchronous reset in the middle of a trigger
    ce_mode = 1;
    dur = 3;
    push(8'd5, 8'd5);
    push(8'd6, 8'd6);
    wait_trigger("t6", 20);
    reset = 1'b1;
    #1;
    model_reset();
    ctrl_done = 1'b1;
    chk("t6_trigger", trigger, 0);
    chk("t6_busy", busy, 0);
    chk("t6_level", level, 0);
    chk("t6_moves", moves_done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  task automatic step_rand();
    case ($urandom_range(0, 1))
      0: clk_en = 1'b1;
      default: clk_en = 1'b0;
    endcase
    step();
  endtask

endmodule

// File: doc/stepper_move_sequencer.md
Name: stepper_move_sequencer

Overview:
Programmable successor to the fixed XY move list used to exercise the stepper controller. Buffers signed X/Y step-count pairs in a parametrised FIFO, loaded over a valid/ready handshake. Dispatches each pair to a downstream StepperCtrlXY-style controller through its trigger/done interface, paced by the shared clk_en tick. Sits between the command decoder and the XY stepper controller.

Parameters:
COUNT_BITS_X, 8, width of signed X step count
COUNT_BITS_Y, 8, width of signed Y step count
DEPTH, 4, FIFO entries; power of two, minimum 2
MOVES_BITS, 16, width of completed-move counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_en  in  1  one-cycle tick pacing the dispatch FSM; same tick drives the downstream controller
in_valid  in  1  move pair offered
in_ready  out  1  FIFO can accept; equals !full
in_steps_x  in  COUNT_BITS_X  signed X steps
in_steps_y  in  COUNT_BITS_Y  signed Y steps
run  in  1  dispatch enable; when low, no new move is triggered
flush  in  1  synchronous FIFO clear
ctrl_done  in  1  downstream idle/done level
trigger  out  1  start pulse to downstream, one clk_en period long
num_steps_x  out  COUNT_BITS_X  registered X count, held stable while the move runs
num_steps_y  out  COUNT_BITS_Y  registered Y count, held stable while the move runs
busy  out  1  high in any state other than IDLE
level  out  $clog2(DEPTH)+1  FIFO occupancy
moves_done  out  MOVES_BITS  moves completed plus zero moves skipped; wraps

Behaviour:
- Reset (asynchronous): FIFO empty; level=0; in_ready=1; FSM=IDLE; trigger=0; num_steps_x/num_steps_y=0; busy=0; moves_done=0.
- FIFO:
  - Write on every clk edge where in_valid && in_ready. Writes are not gated by clk_en.
  - Pop occurs only from the FSM, on a clk_en cycle.
  - Simultaneous write and pop when full: the write is refused, because in_ready is based on the pre-pop level.
  - Simultaneous write and pop when empty cannot occur.
  - Pointers wrap modulo DEPTH.
- flush:
  - Empties the FIFO on the same edge and drops any same-cycle write.
  - Does not abort a move already triggered. The FSM finishes WAIT_DONE, then returns to IDLE.
- FSM: all transitions happen only on clk_en=1 edges; between ticks, state and outputs hold.
  - IDLE: if run && level>0 && ctrl_done, pop the head entry.
    - If the entry is nonzero: latch it into num_steps_x/num_steps_y and go to TRIGGER.
    - If both fields are zero: discard it, increment moves_done, and stay in IDLE. This is the zero-move skip; it uses one tick per entry.
  - TRIGGER: trigger=1 for exactly this clk_en period. Go to WAIT_DONE on the next tick.
  - WAIT_DONE:
    - Downstream contract: ctrl_done goes low on the tick that samples trigger.
    - On a tick with ctrl_done=1: increment moves_done. Then pop the next entry directly, as in IDLE, if run && level>0. Otherwise go to IDLE.
    - Back-to-back moves therefore have a 2-tick spacing: WAIT_DONE→TRIGGER.
- run deasserted mid-move: the current move completes and no new pop occurs. Raising run again resumes from the FIFO head.
- num_steps_x/num_steps_y change only at a pop; they hold their last value in IDLE.
- moves_done wraps from 2^MOVES_BITS-1 to 0.
- Reset asserted mid-operation: all state clears immediately. Buffered moves are lost and trigger drops asynchronously.

Test Plan:
1. DEPTH=4, run=1, ctrl_done model with 3-tick moves. Load (2,3), (0,-5), (-7,4), (-2,0). Required: four trigger pulses in order with num_steps_y=8'hFB on the 2nd; moves_done=4; busy then falls; level=0.
2. Fill the FIFO with run=0 and offer a 5th entry. Required: in_ready=0 at level=4 and the 5th write is not accepted. Raise run; in_ready returns high after the first pop.
3. Queue (0,0), (1,1). Required: no trigger for (0,0); moves_done=1 before the first trigger; num_steps_x=1 on that trigger.
4. Assert flush for one clk while a move is in WAIT_DONE with 2 queued entries. Required: level=0 next edge; the current move completes; moves_done +1; FSM returns to IDLE with no further trigger.
5. Drop run during WAIT_DONE with 1 queued entry. Required: no trigger after done and level stays 1. Raise run; a trigger follows within 1 tick.
6. Assert reset between clk edges mid-TRIGGER. Required: trigger=0, busy=0, level=0, moves_done=0 immediately, without waiting for a clk edge.
